// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game controller.
//   state_t    : controller state encoding
//   RED..YELLOW: 2-bit colour codes as understood by color_decoder
//   LFSR_MASK  : feedback taps of the 16-bit Galois generator
//   lfsr_step  : one shift of the Galois generator
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADD      = 3'd1,
    SHOW_ON  = 3'd2,
    SHOW_OFF = 3'd3,
    WAIT_IN  = 3'd4,
    WIN      = 3'd5,
    LOSE     = 3'd6
  } state_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] GREEN  = 2'd1;
  localparam logic [1:0] BLUE   = 2'd2;
  localparam logic [1:0] YELLOW = 2'd3;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Right-shifting Galois form: the bit falling out of bit 0 decides
  // whether the taps are folded back in.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = cur[0] ? ({1'b0, cur[15:1]} ^ LFSR_MASK) : {1'b0, cur[15:1]};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit Galois LFSR supplying new colour codes.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, reloads SEED
//   code : two low bits of the current generator value
// SEED must be non-zero or the generator locks up at zero.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:0] code
);

  logic [15:0] lfsr;

  // Shifts on every cycle regardless of game state, so the moment the
  // player hits start decides which codes come out.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign code = lfsr[1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon game controller: grows a random colour sequence one code per round,
// plays it back with timed lit/blank phases, then checks player presses.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   start      : one-cycle pulse, starts a new game from IDLE/WIN/LOSE
//   btn_valid  : one-cycle pulse marking a player press
//   btn_code   : pressed colour (0 red, 1 green, 2 blue, 3 yellow)
//   color_vec  : to color_decoder, current code replicated in all four fields
//   disp_en    : 1 while a code is lit
//   level      : current sequence length
//   busy       : high while adding/playing back
//   win, lose  : game result flags
// Build option: define SIMON_TIMEOUT_EN to make an idle player lose after
// TIMEOUT_TICKS ticks in WAIT_IN; without it WAIT_IN waits forever.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int          MAX_LEN       = 16,
  parameter int          TICK_DIV      = 25000000,
  parameter int          ON_TICKS      = 2,
  parameter int          OFF_TICKS     = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter int          TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn_code,
  output logic [7:0] color_vec,
  output logic       disp_en,
  output logic [5:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // One tick counter serves every timed state, so size it for the longest.
  localparam int TK_MAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TK_MAX  = (TIMEOUT_TICKS > TK_MAX0) ? TIMEOUT_TICKS : TK_MAX0;
  localparam int TK_W    = (TK_MAX > 1) ? $clog2(TK_MAX) : 1;

  state_t           state, state_nx;
  logic [5:0]       len, len_nx;
  logic [5:0]       idx, idx_nx;
  logic [1:0]       mem [MAX_LEN];
  logic [1:0]       mem_rd;
  logic [1:0]       rnd_code;
  logic [1:0]       cur_code;
  logic             mem_we;
  logic             timer_clr;
  logic [PRE_W-1:0] pre;
  logic [TK_W-1:0]  ticks;
  logic             tick;
  logic             on_done;
  logic             off_done;
  logic             last;
`ifdef SIMON_TIMEOUT_EN
  logic             to_done;
`endif

  simon_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .code (rnd_code)
  );

  assign mem_rd   = mem[idx[AW-1:0]];
  assign tick     = (pre == PRE_W'(TICK_DIV - 1));
  assign on_done  = tick && (ticks == TK_W'(ON_TICKS - 1));
  assign off_done = tick && (ticks == TK_W'(OFF_TICKS - 1));
  assign last     = ((idx + 6'd1) == len);
`ifdef SIMON_TIMEOUT_EN
  assign to_done  = tick && (ticks == TK_W'(TIMEOUT_TICKS - 1));
`endif

  always_comb begin
    state_nx  = state;
    len_nx    = len;
    idx_nx    = idx;
    mem_we    = 1'b0;
    timer_clr = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_nx = ADD;
          len_nx   = 6'd0;
          idx_nx   = 6'd0;
        end
      end
      ADD: begin
        mem_we   = 1'b1;
        len_nx   = len + 6'd1;
        idx_nx   = 6'd0;
        state_nx = SHOW_ON;
      end
      SHOW_ON: begin
        if (on_done) state_nx = SHOW_OFF;
      end
      SHOW_OFF: begin
        if (off_done) begin
          if (last) begin
            idx_nx   = 6'd0;
            state_nx = WAIT_IN;
          end else begin
            idx_nx   = idx + 6'd1;
            state_nx = SHOW_ON;
          end
        end
      end
      WAIT_IN: begin
        if (btn_valid) begin
          if (btn_code == mem_rd) begin
            if (last) begin
              state_nx = (len == 6'(MAX_LEN)) ? WIN : ADD;
            end else begin
              idx_nx    = idx + 6'd1;
              // each correct press grants the player a fresh timeout window
              timer_clr = 1'b1;
            end
          end else begin
            state_nx = LOSE;
          end
        end
`ifdef SIMON_TIMEOUT_EN
        else if (to_done) begin
          state_nx = LOSE;
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
    // every state change restarts the phase timer from zero
    if (state_nx != state) timer_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len   <= 6'd0;
      idx   <= 6'd0;
    end else begin
      state <= state_nx;
      len   <= len_nx;
      idx   <= idx_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[len[AW-1:0]] <= rnd_code;
  end

  always_ff @(posedge clk) begin
    if (rst || timer_clr) begin
      pre   <= '0;
      ticks <= '0;
    end else if (tick) begin
      pre   <= '0;
      ticks <= ticks + TK_W'(1);
    end else begin
      pre   <= pre + PRE_W'(1);
    end
  end

  // Remembers the last lit code so the decoder keeps a stable value while
  // the display is blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_code <= RED;
    end else if (state == SHOW_ON) begin
      cur_code <= mem_rd;
    end
  end

  assign color_vec = (state == SHOW_ON) ? {4{mem_rd}} : {4{cur_code}};
  assign disp_en   = (state == SHOW_ON);
  assign level     = len;
  assign busy      = (state == ADD) || (state == SHOW_ON) || (state == SHOW_OFF);
  assign win       = (state == WIN);
  assign lose      = (state == LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer: randomized games against a
// reference game model; lit phases are checked by a scoreboard monitor.
module tb_simon_sequencer;

  localparam int          MAXL   = 4;
  localparam int          TDIV   = 2;
  localparam int          ONT    = 3;
  localparam int          OFFT   = 1;
  localparam int          TOT    = 8;
  localparam int          ON_CYC = TDIV * ONT;
  localparam int          SLOT   = TDIV * (ONT + OFFT);
  localparam logic [15:0] SEED   = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic [7:0] color_vec;
  logic       disp_en;
  logic [5:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  simon_sequencer #(
    .MAX_LEN       (MAXL),
    .TICK_DIV      (TDIV),
    .ON_TICKS      (ONT),
    .OFF_TICKS     (OFFT),
    .LFSR_SEED     (SEED),
    .TIMEOUT_TICKS (TOT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .color_vec (color_vec),
    .disp_en   (disp_en),
    .level     (level),
    .busy      (busy),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] mlfsr;
  logic [1:0]  seq  [$];
  logic [1:0]  expq [$];

  // Reference random generator: right shift, fold taps 0xB400 when the
  // outgoing bit is 1; reloads the seed whenever reset is sampled.
  always @(posedge clk) begin
    if (rst) mlfsr <= SEED;
    else     mlfsr <= mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lit-phase monitor: each rising disp_en pops one expected code; the
  // phase must last ON_CYC cycles showing that code in all four fields.
  logic       in_ph = 1'b0;
  logic       have  = 1'b0;
  logic       col_bad;
  logic [7:0] bad_col;
  logic [1:0] cur_exp;
  int         lit_cnt;

  always @(negedge clk) begin
    if (rst) begin
      in_ph = 1'b0;
      have  = 1'b0;
      expq.delete();
    end else if (disp_en) begin
      if (!in_ph) begin
        in_ph   = 1'b1;
        lit_cnt = 0;
        col_bad = 1'b0;
        if (expq.size() == 0) begin
          total++;
          bad++;
          have = 1'b0;
          $display("FAIL lit_unexpected: got lit phase, want none (t=%0t)", $time);
        end else begin
          cur_exp = expq.pop_front();
          have    = 1'b1;
        end
      end
      lit_cnt++;
      if (have && !col_bad && (color_vec !== {4{cur_exp}})) begin
        col_bad = 1'b1;
        bad_col = color_vec;
      end
    end else if (in_ph) begin
      in_ph = 1'b0;
      if (have) begin
        chk("lit_len", 32'(lit_cnt), 32'(ON_CYC));
        total++;
        if (col_bad) begin
          bad++;
          $display("FAIL lit_color: got %0h, want %0h (t=%0t)", bad_col, {4{cur_exp}}, $time);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    start     = 1'b0;
    btn_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic press(input logic [1:0] c, input bit with_start);
    btn_valid = 1'b1;
    btn_code  = c;
    start     = with_start;
    step();
    btn_valid = 1'b0;
    start     = 1'b0;
  endtask

  // Called during the ADD cycle of a round of length L; returns in WAIT_IN.
  task automatic play_round(input int L);
    bit noise;
    foreach (seq[i]) expq.push_back(seq[i]);
    noise = 1'($urandom_range(0, 1));
    for (int k = 0; k < SLOT * L; k++) begin
      if (noise && k != SLOT * L - 1) begin
        btn_valid = ($urandom_range(0, 2) == 0);
        btn_code  = 2'($urandom_range(0, 3));
        start     = ($urandom_range(0, 5) == 0);
      end else begin
        btn_valid = 1'b0;
        start     = 1'b0;
      end
      step();
      if (k == 0) begin
        chk("round_level", 32'(level), 32'(L));
        chk("round_busy", 32'(busy), 1);
      end
    end
    chk("show_end_busy", 32'(busy), 1);
    step();
    chk("wait_busy", 32'(busy), 0);
    chk("wait_disp", 32'(disp_en), 0);
    chk("wait_level", 32'(level), 32'(L));
    chk("wait_lose", 32'(lose), 0);
  endtask

  task automatic new_game();
    start     = 1'b1;
    btn_valid = 1'($urandom_range(0, 1));
    btn_code  = 2'($urandom_range(0, 3));
    step();
    start     = 1'b0;
    btn_valid = 1'b0;
    chk("start_busy", 32'(busy), 1);
    chk("start_win", 32'(win), 0);
    chk("start_lose", 32'(lose), 0);
    seq.delete();
    seq.push_back(mlfsr[1:0]);
    play_round(1);
  endtask

  // fail_round 0 plays to a win; otherwise a wrong press in that round.
  task automatic run_game(input int fail_round);
    new_game();
    for (int r = 1; r <= MAXL; r++) begin
      int wrong_at;
      wrong_at = (r == fail_round) ? $urandom_range(0, r - 1) : -1;
      for (int i = 0; i < r; i++) begin
        idle($urandom_range(0, 3));
        if (i == wrong_at) begin
          press(seq[i] ^ 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
          chk("lose_flag", 32'(lose), 1);
          chk("lose_disp", 32'(disp_en), 0);
          chk("lose_level", 32'(level), 32'(r));
          chk("lose_busy", 32'(busy), 0);
          chk("lose_win", 32'(win), 0);
          for (int j = 0; j < 4; j++) press(2'($urandom_range(0, 3)), 1'b0);
          chk("lose_hold", 32'(lose), 1);
          chk("lose_hold_level", 32'(level), 32'(r));
          return;
        end
        press(seq[i], 1'($urandom_range(0, 1)));
        if (i < r - 1) begin
          chk("mid_busy", 32'(busy), 0);
          chk("mid_lose", 32'(lose), 0);
        end
      end
      if (r == MAXL) begin
        chk("win_flag", 32'(win), 1);
        chk("win_level", 32'(level), 32'(MAXL));
        chk("win_busy", 32'(busy), 0);
        chk("win_lose", 32'(lose), 0);
        for (int j = 0; j < 3; j++) press(2'($urandom_range(0, 3)), 1'b0);
        chk("win_hold", 32'(win), 1);
        chk("win_hold_level", 32'(level), 32'(MAXL));
      end else begin
        seq.push_back(mlfsr[1:0]);
        play_round(r + 1);
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_color"}, 32'(color_vec), 0);
    chk({tag, "_disp"}, 32'(disp_en), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_win"}, 32'(win), 0);
    chk({tag, "_lose"}, 32'(lose), 0);
    chk({tag, "_lfsr"}, 32'(dut.u_lfsr.lfsr), 32'(SEED));
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_code  = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    idle(5);
    press(2'($urandom_range(0, 3)), 1'b0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_lose", 32'(lose), 0);
    chk("idle_level", 32'(level), 0);

    run_game(0);
    run_game(2);

    // restart after lose, then reset in the middle of a lit phase
    new_game();
    press(seq[0], 1'b0);
    seq.push_back(mlfsr[1:0]);
    foreach (seq[i]) expq.push_back(seq[i]);
    step();
    step();
    chk("pre_reset_lit", 32'(disp_en), 1);
    rst       = 1'b1;
    btn_valid = 1'b1;
    btn_code  = 2'($urandom_range(0, 3));
    step();
    rst       = 1'b0;
    btn_valid = 1'b0;
    chk_reset_vals("midrst");
    idle(3);

`ifdef SIMON_TIMEOUT_EN
    new_game();
    idle(TDIV * TOT - 1);
    chk("to_before", 32'(lose), 0);
    idle(1);
    chk("to_expire", 32'(lose), 1);
    new_game();
    press(seq[0], 1'b0);
    seq.push_back(mlfsr[1:0]);
    play_round(2);
    idle(TDIV * TOT - 1);
    press(seq[0], 1'b0);
    chk("to_press_lose", 32'(lose), 0);
    chk("to_press_busy", 32'(busy), 0);
    idle(TDIV * TOT - 1);
    chk("to_restart_before", 32'(lose), 0);
    idle(1);
    chk("to_restart_expire", 32'(lose), 1);
`else
    new_game();
    idle(40);
    chk("no_timeout_lose", 32'(lose), 0);
    chk("no_timeout_busy", 32'(busy), 0);
    press(seq[0] ^ 2'd1, 1'b0);
    chk("late_wrong_lose", 32'(lose), 1);
`endif

    for (int g = 0; g < 4; g++) run_game($urandom_range(0, MAXL));

    idle(2);
    chk("scoreboard_empty", 32'(expq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
